trng_sample_ctrl: RTL and testbench

- Sequences the 14-ring single-bit entropy sampler and turns its raw output into WIDTH-bit random words.
- Synchronises the raw bit and decimates it by a programmable period.
- Discards a warm-up run after every enable and applies a repetition-count health test.
- Presents finished words on a valid/ready handshake to the downstream consumer.

---
 rtl/trng_sample_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_trng_sample_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/trng_sample_ctrl.sv
// Entropy sampler controller: synchronises and decimates the raw ring bit, discards a warm-up run,
// applies a repetition-count health test and packs samples into WIDTH-bit words.
module trng_sample_ctrl #(
  parameter int WIDTH     = 32,
  parameter int DIV_W     = 8,
  parameter int WARMUP    = 256,
  parameter int REP_LIMIT = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             raw_bit,
  input  logic [DIV_W-1:0] div,
  input  logic             rnd_ready,
  input  logic             clr_fault,
  output logic [WIDTH-1:0] rnd_data,
  output logic             rnd_valid,
  output logic             health_fail,
  output logic             busy,
  output logic [2:0]       dbg_state
);

  localparam int WARM_W = $clog2(WARMUP + 1);
  localparam int BIT_W  = $clog2(WIDTH + 1);
  localparam int RUN_W  = $clog2(REP_LIMIT + 1);

  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);
  localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(REP_LIMIT);
  localparam logic [RUN_W-1:0]  RUN_ONE   = RUN_W'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WARMUP  = 3'd1,
    S_COLLECT = 3'd2,
    S_HOLD    = 3'd3,
    S_FAULT   = 3'd4
  } state_t;

  state_t            r_state;
  logic              r_sync1;
  logic              r_sbit;
  logic [DIV_W-1:0]  r_tick_cnt;
  logic [WARM_W-1:0] r_warm_cnt;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic [WIDTH-1:0]  r_shift;
  logic              r_last;
  logic [RUN_W-1:0]  r_run;
  logic              r_first;
  logic [WIDTH-1:0]  r_data;
  logic              r_valid;
  logic              r_fail;
  logic              r_busy;

  logic              w_sampling;
  logic              w_tick;
  logic [RUN_W-1:0]  w_run_inc;
  logic [RUN_W-1:0]  w_run_next;
  logic              w_rep_fail;
  logic [WIDTH-1:0]  w_shift_next;

  // Handshake: a word transfers on any cycle where rnd_valid && rnd_ready; rnd_data is held
  // stable while rnd_valid is high, and rnd_valid never drops without a transfer except on FAULT.
  assign w_sampling   = (r_state == S_WARMUP) || (r_state == S_COLLECT);
  assign w_tick       = w_sampling && (r_tick_cnt == div);
  assign w_run_inc    = (r_run == RUN_MAX) ? r_run : r_run + RUN_ONE;
  assign w_run_next   = r_first ? RUN_ONE : ((r_sbit == r_last) ? w_run_inc : RUN_ONE);
  assign w_rep_fail   = w_tick && (w_run_next == RUN_MAX);
  assign w_shift_next = {r_shift[WIDTH-2:0], r_sbit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sbit  <= 1'b0;
    end else begin
      r_sync1 <= raw_bit;
      r_sbit  <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_tick_cnt <= '0;
      r_warm_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_last     <= 1'b0;
      r_run      <= '0;
      r_first    <= 1'b0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_fail     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      // Run/last survive WARMUP->COLLECT and HOLD->COLLECT so a stuck source cannot hide across them.
      if (w_tick) begin
        r_last  <= r_sbit;
        r_run   <= w_run_next;
        r_first <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (en) begin
            r_state    <= S_WARMUP;
            r_busy     <= 1'b1;
            r_tick_cnt <= '0;
            r_warm_cnt <= '0;
            r_first    <= 1'b1;
          end
        end
        S_WARMUP: begin
          if (!en) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (w_rep_fail) begin
            r_state <= S_FAULT;
            r_fail  <= 1'b1;
          end else if (w_tick) begin
            r_tick_cnt <= '0;
            if (r_warm_cnt == WARM_LAST) begin
              r_state   <= S_COLLECT;
              r_bit_cnt <= '0;
              r_shift   <= '0;
            end else begin
              r_warm_cnt <= r_warm_cnt + WARM_W'(1);
            end
          end else begin
            r_tick_cnt <= r_tick_cnt + DIV_W'(1);
          end
        end
        S_COLLECT: begin
          if (!en) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (w_rep_fail) begin
            r_state <= S_FAULT;
            r_fail  <= 1'b1;
            r_valid <= 1'b0;
          end else if (w_tick) begin
            r_tick_cnt <= '0;
            if (r_bit_cnt == BIT_LAST) begin
              r_state <= S_HOLD;
              r_data  <= w_shift_next;
              r_valid <= 1'b1;
            end else begin
              r_shift   <= w_shift_next;
              r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            end
          end else begin
            r_tick_cnt <= r_tick_cnt + DIV_W'(1);
          end
        end
        S_HOLD: begin
          if (r_valid && rnd_ready) begin
            r_valid <= 1'b0;
            if (en) begin
              r_state    <= S_COLLECT;
              r_tick_cnt <= '0;
              r_bit_cnt  <= '0;
              r_shift    <= '0;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        S_FAULT: begin
          if (clr_fault) begin
            r_state <= S_IDLE;
            r_fail  <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign rnd_data    = r_data;
  assign rnd_valid   = r_valid;
  assign health_fail = r_fail;
  assign busy        = r_busy;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_trng_sample_ctrl.sv
// Directed bench for trng_sample_ctrl (WIDTH=8, WARMUP=4, REP_LIMIT=5); inputs change on the
// falling edge so every sample position relative to the rising edge is fixed and hand-countable.
module tb_trng_sample_ctrl;

  localparam int WIDTH     = 8;
  localparam int DIV_W     = 8;
  localparam int WARMUP    = 4;
  localparam int REP_LIMIT = 5;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WARMUP  = 3'd1;
  localparam logic [2:0] ST_COLLECT = 3'd2;
  localparam logic [2:0] ST_HOLD    = 3'd3;
  localparam logic [2:0] ST_FAULT   = 3'd4;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             raw_bit;
  logic [DIV_W-1:0] div;
  logic             rnd_ready;
  logic             clr_fault;
  logic [WIDTH-1:0] rnd_data;
  logic             rnd_valid;
  logic             health_fail;
  logic             busy;
  logic [2:0]       dbg_state;

  int errors = 0;
  int checks = 0;

  trng_sample_ctrl #(
    .WIDTH(WIDTH), .DIV_W(DIV_W), .WARMUP(WARMUP), .REP_LIMIT(REP_LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .raw_bit(raw_bit), .div(div),
    .rnd_ready(rnd_ready), .clr_fault(clr_fault), .rnd_data(rnd_data),
    .rnd_valid(rnd_valid), .health_fail(health_fail), .busy(busy), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // raw(e+j) = (j odd); with div=0 the collected samples are raw(e+3..e+10) -> 8'hAA.
  task automatic start_alt(input int ncyc);
    raw_bit = 1'b1;
    cyc();
    en      = 1'b1;
    raw_bit = 1'b0;
    for (int j = 1; j <= ncyc; j++) begin
      cyc();
      check("alt_busy", busy, 1);
      check("alt_valid_low", rnd_valid, 0);
      raw_bit = j[0];
    end
  endtask

  // With div=3 the samples are raw(e+2+4n); between samples drive the complement.
  function automatic logic raw_dec(input int j);
    logic even;
    even = ((j / 4) % 2) == 0;
    return ((j % 4) == 2) ? even : !even;
  endfunction

  initial begin
    logic [7:0] pat;
    logic       hold_ok;
    rst_n = 1'b0; en = 1'b0; raw_bit = 1'b0; div = '0; rnd_ready = 1'b0; clr_fault = 1'b0;
    cyc(); cyc();
    check("rst_data", rnd_data, 0);
    check("rst_valid", rnd_valid, 0);
    check("rst_fail", health_fail, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, ST_IDLE);
    rst_n = 1'b1;
    cyc();

    // Warm-up discard, first word after WARMUP+WIDTH ticks.
    start_alt(12);
    cyc();
    check("warm_valid", rnd_valid, 1);
    check("warm_data", rnd_data, 8'hAA);
    check("warm_busy", busy, 1);

    // Backpressure with a stray clr_fault while holding.
    raw_bit = 1'b1;
    hold_ok = 1'b1;
    for (int k = 0; k < 50; k++) begin
      clr_fault = (k == 20);
      cyc();
      hold_ok &= (rnd_valid === 1'b1) && (rnd_data === 8'hAA) && (dbg_state === ST_HOLD);
    end
    clr_fault = 1'b0;
    check("bp_stable", hold_ok, 1);
    check("bp_no_fail", health_fail, 0);

    pat       = 8'hCC;
    rnd_ready = 1'b1;
    cyc();
    rnd_ready = 1'b0;
    check("hs_state", dbg_state, ST_COLLECT);
    for (int m = 0; m < 8; m++) begin
      check("word2_wait", rnd_valid, 0);
      if (m <= 5) raw_bit = pat[5-m];
      cyc();
    end
    check("word2_valid", rnd_valid, 1);
    check("word2_data", rnd_data, 8'hCC);

    rnd_ready = 1'b1; en = 1'b0;
    cyc();
    rnd_ready = 1'b0;
    check("acc2_state", dbg_state, ST_IDLE);
    check("acc2_valid", rnd_valid, 0);

    // Decimation div=3: first word exactly 48 cycles after en is seen.
    div     = 8'd3;
    en      = 1'b1;
    raw_bit = raw_dec(0);
    for (int j = 1; j <= 48; j++) begin
      cyc();
      if (j == 48) check("dec_valid_early", rnd_valid, 0);
      raw_bit = raw_dec(j);
    end
    cyc();
    check("dec_valid", rnd_valid, 1);
    check("dec_data", rnd_data, 8'hAA);

    rnd_ready = 1'b1; en = 1'b0;
    cyc();
    rnd_ready = 1'b0;
    div       = '0;
    check("acc3_state", dbg_state, ST_IDLE);

    // Abort after 3 collected bits, then a full warm-up again.
    start_alt(8);
    check("abort_pre_state", dbg_state, ST_COLLECT);
    en = 1'b0;
    cyc();
    check("abort_busy", busy, 0);
    check("abort_valid", rnd_valid, 0);
    check("abort_state", dbg_state, ST_IDLE);
    start_alt(12);
    cyc();
    check("rerun_valid", rnd_valid, 1);
    check("rerun_data", rnd_data, 8'hAA);
    rnd_ready = 1'b1; en = 1'b0;
    cyc();
    rnd_ready = 1'b0;
    check("acc4_state", dbg_state, ST_IDLE);

    // Health fault: stuck-at-0 trips on the 5th sample.
    raw_bit = 1'b0;
    cyc(); cyc();
    en = 1'b1;
    for (int j = 1; j <= 5; j++) cyc();
    check("fault_pre", health_fail, 0);
    cyc();
    check("fault_flag", health_fail, 1);
    check("fault_valid", rnd_valid, 0);
    check("fault_busy", busy, 1);
    check("fault_state", dbg_state, ST_FAULT);
    en = 1'b0;
    cyc(); cyc(); cyc();
    check("fault_en0_state", dbg_state, ST_FAULT);
    check("fault_en0_busy", busy, 1);
    en = 1'b1;
    cyc(); cyc();
    check("fault_en1_state", dbg_state, ST_FAULT);
    check("fault_en1_flag", health_fail, 1);
    clr_fault = 1'b1;
    cyc();
    clr_fault = 1'b0;
    check("clr_state", dbg_state, ST_IDLE);
    check("clr_flag", health_fail, 0);
    check("clr_busy", busy, 0);
    cyc();
    check("clr_rewarm", dbg_state, ST_WARMUP);
    en = 1'b0;
    cyc();
    check("clr_off", dbg_state, ST_IDLE);

    // Asynchronous reset while holding a valid word.
    start_alt(12);
    cyc();
    check("ar_pre_valid", rnd_valid, 1);
    #2;
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    check("ar_valid", rnd_valid, 0);
    check("ar_data", rnd_data, 0);
    check("ar_fail", health_fail, 0);
    check("ar_busy", busy, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    check("ar_state", dbg_state, ST_IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
